// File: rtl/uart_pkg.sv
// Shared types, ASCII constants and divider helper for the decimal UART receiver.
// Optional UART_RX_PARITY_EN adds an even-parity state to the bit FSM.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_PARITY,
        BIT_STOP
    } bit_state_e;
`else
    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } bit_state_e;
`endif

    typedef enum logic [1:0] {
        P_EMPTY,
        P_DIGITS,
        P_SUFFIX,
        P_BAD
    } parse_state_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_C     = 8'h63;
    localparam logic [7:0] ASCII_M     = 8'h6D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    function automatic int unsigned DIV(input int unsigned clk_hz,
                                        input int unsigned baud,
                                        input int unsigned osr);
        return clk_hz / (baud * osr);
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// UART byte receiver: 2-FF synchroniser, oversample tick divider and bit FSM.
// With UART_RX_PARITY_EN an even-parity bit follows D7; mismatch reports frame_err.
module uart_rx_8n1 #(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 9600,
    parameter int unsigned OSR    = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    import uart_pkg::*;

    localparam int unsigned TICK_DIV = DIV(CLK_HZ, BAUD, OSR);
    localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned OW = (OSR > 1) ? $clog2(OSR) : 1;

    logic [1:0]    sync_q;
    logic          prev_q;
    bit_state_e    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [OW-1:0] os_q, os_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          bv_q, bv_d;
    logic          fe_q, fe_d;
    logic          rx_s, tick, os_wrap, sample, stop_good;
`ifdef UART_RX_PARITY_EN
    logic          par_err_q, par_err_d;
    assign stop_good = rx_s & ~par_err_q;
`else
    assign stop_good = rx_s;
`endif

    assign rx_s    = sync_q[1];
    assign tick    = (div_q == DW'(TICK_DIV - 1));
    assign os_wrap = (os_q == OW'(OSR - 1));
    assign sample  = tick && os_wrap;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '1;
            prev_q    <= 1'b1;
            state_q   <= BIT_IDLE;
            div_q     <= '0;
            os_q      <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            bv_q      <= 1'b0;
            fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], rx_i};
            prev_q    <= rx_s;
            state_q   <= state_d;
            div_q     <= div_d;
            os_q      <= os_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            bv_q      <= bv_d;
            fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        os_d      = os_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        bv_d      = 1'b0;
        fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        // Divider only runs outside IDLE, so START always begins from a zero count
        if (state_q == BIT_IDLE || tick) div_d = '0;
        else                             div_d = div_q + 1'b1;
        if (state_q != BIT_IDLE && tick) os_d = os_wrap ? '0 : os_q + 1'b1;

        case (state_q)
            BIT_IDLE: begin
                // Edge detect needs a high sample first, so a held break never re-arms
                if (prev_q && !rx_s) begin
                    state_d = BIT_START;
                    os_d    = '0;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end
            end
            BIT_START: begin
                if (tick && os_q == OW'(OSR / 2 - 1)) begin
                    os_d  = '0;
                    bit_d = '0;
                    state_d = rx_s ? BIT_IDLE : BIT_DATA;
                end
            end
            BIT_DATA: begin
                if (sample) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = BIT_PARITY;
`else
                        state_d = BIT_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            BIT_PARITY: begin
                if (sample) begin
                    par_err_d = rx_s ^ (^shift_q);
                    state_d   = BIT_STOP;
                end
            end
`endif
            BIT_STOP: begin
                if (sample) begin
                    if (stop_good) begin
                        byte_d = shift_q;
                        bv_d   = 1'b1;
                    end else begin
                        fe_d   = 1'b1;
                    end
                    state_d = BIT_IDLE;
                end
            end
            default: state_d = BIT_IDLE;
        endcase
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = bv_q;
    assign frame_err_o  = fe_q;

endmodule

// File: rtl/uart_rx_decimal.sv
// UART receiver with an ASCII decimal line parser ("<digits>[cm]<CR|LF>").
// Define UART_RX_PARITY_EN for 8E1 framing in the byte receiver.
module uart_rx_decimal #(
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned MAX_DIGITS = 5,
    parameter int unsigned OSR        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        frame_err,
    output logic        parse_err
);
    import uart_pkg::*;

    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    logic [7:0]   byte_w;
    logic         bv_w, fe_w;
    parse_state_e pstate_q, pstate_d;
    logic [15:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]  value_q, value_d;
    logic         vv_q, vv_d;
    logic         pe_q, pe_d;
    logic [7:0]   digit_off;
    logic [16:0]  acc_next;
    logic         is_term, is_digit, is_suffix;

    uart_rx_8n1 #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .OSR    (OSR)
    ) u_rx (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx),
        .byte_o       (byte_w),
        .byte_valid_o (bv_w),
        .frame_err_o  (fe_w)
    );

    assign digit_off = byte_w - ASCII_0;
    assign is_term   = (byte_w == ASCII_CR) || (byte_w == ASCII_LF);
    assign is_digit  = (byte_w >= ASCII_0) && (byte_w <= ASCII_9);
    assign is_suffix = (byte_w == ASCII_C) || (byte_w == ASCII_M) || (byte_w == ASCII_SPACE);
    // 17 bits suffice: the digit-count limit stops the accumulator before it can wrap
    assign acc_next  = ({1'b0, acc_q} * 17'd10) + {13'd0, digit_off[3:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate_q <= P_EMPTY;
            acc_q    <= '0;
            cnt_q    <= '0;
            value_q  <= '0;
            vv_q     <= 1'b0;
            pe_q     <= 1'b0;
        end else begin
            pstate_q <= pstate_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            vv_q     <= vv_d;
            pe_q     <= pe_d;
        end
    end

    always_comb begin
        pstate_d = pstate_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        vv_d     = 1'b0;
        pe_d     = 1'b0;
        if (fe_w) begin
            pstate_d = P_BAD;
        end else if (bv_w) begin
            if (is_term) begin
                if (pstate_q == P_DIGITS || pstate_q == P_SUFFIX) begin
                    value_d = acc_q;
                    vv_d    = 1'b1;
                end else if (pstate_q == P_BAD) begin
                    pe_d    = 1'b1;
                end
                acc_d    = '0;
                cnt_d    = '0;
                pstate_d = P_EMPTY;
            end else if (is_digit) begin
                if (pstate_q == P_EMPTY || pstate_q == P_DIGITS) begin
                    if (cnt_q >= CW'(MAX_DIGITS) || acc_next > 17'd65535) begin
                        pstate_d = P_BAD;
                    end else begin
                        acc_d    = acc_next[15:0];
                        cnt_d    = cnt_q + 1'b1;
                        pstate_d = P_DIGITS;
                    end
                end else begin
                    pstate_d = P_BAD;
                end
            end else if (is_suffix && (pstate_q == P_DIGITS || pstate_q == P_SUFFIX)) begin
                pstate_d = P_SUFFIX;
            end else begin
                pstate_d = P_BAD;
            end
        end
    end

    assign rx_byte       = byte_w;
    assign rx_byte_valid = bv_w;
    assign frame_err     = fe_w;
    assign value         = value_q;
    assign value_valid   = vv_q;
    assign parse_err     = pe_q;

endmodule

// File: tb/tb_uart_rx_decimal.sv
// Directed bench for uart_rx_decimal: line-level model produces an ordered event queue
// that a per-cycle compare process consumes; literal pins check the model itself.
module tb_uart_rx_decimal;

    localparam int unsigned CLK_HZ = 700000;
    localparam int unsigned BAUD   = 9600;
    localparam int unsigned OSR    = 16;
    localparam int unsigned MAXD   = 5;
    // 700000/(9600*16) truncates to 4 clocks per tick, 16 ticks per bit
    localparam int BIT_CLKS = 64;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [15:0] value;
    logic        value_valid;
    logic        frame_err;
    logic        parse_err;

    always #5 clk = ~clk;

    uart_rx_decimal #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .MAX_DIGITS (MAXD),
        .OSR        (OSR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .value         (value),
        .value_valid   (value_valid),
        .frame_err     (frame_err),
        .parse_err     (parse_err)
    );

    typedef enum int {EV_BYTE, EV_VALUE, EV_PERR, EV_FERR} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       data;
    } ev_t;

    ev_t     exp_q[$];
    int      line[$];
    bit      line_bad = 1'b0;
    int      exp_value = 0;
    int      checks = 0;
    int      errors = 0;
    int      n_byte = 0, n_val = 0, n_perr = 0, n_ferr = 0;
    int      s_byte = 0, s_val = 0, s_perr = 0, s_ferr = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_ev(input ev_kind_e k, input int d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Judge a whole line at its terminator: digits, then only suffix chars
    task automatic eval_line(output bit ok, output int v);
        int  nd = 0;
        int  i  = 0;
        longint acc = 0;
        ok = 1'b1;
        while (i < line.size() && line[i] >= 8'h30 && line[i] <= 8'h39) begin
            acc = acc * 10 + (line[i] - 8'h30);
            nd++;
            i++;
        end
        for (int j = i; j < line.size(); j++)
            if (!(line[j] == 8'h63 || line[j] == 8'h6D || line[j] == 8'h20)) ok = 1'b0;
        if (nd == 0 || nd > int'(MAXD) || acc > 65535) ok = 1'b0;
        v = int'(acc);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        bit ok;
        int v;
        if (!good) begin
            push_ev(EV_FERR, 1);
            line_bad = 1'b1;
            return;
        end
        push_ev(EV_BYTE, int'(b));
        if (b == CR || b == LF) begin
            if (line_bad) push_ev(EV_PERR, 1);
            else if (line.size() != 0) begin
                eval_line(ok, v);
                if (ok) push_ev(EV_VALUE, v);
                else    push_ev(EV_PERR, 1);
            end
            line.delete();
            line_bad = 1'b0;
        end else begin
            line.push_back(int'(b));
        end
    endtask

    task automatic pop_expect(input ev_kind_e kind, input int act, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s actual=%0d required=no_strobe", name, act);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, int'(kind), int'(e.kind));
            if (kind == EV_VALUE) exp_value = e.data;
            chk(name, act, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs",
                int'({rx_byte, rx_byte_valid, value, value_valid, frame_err, parse_err}), 0);
            exp_value = 0;
        end else begin
            if (rx_byte_valid) begin n_byte++; pop_expect(EV_BYTE, int'(rx_byte), "rx_byte"); end
            if (value_valid)   begin n_val++;  pop_expect(EV_VALUE, int'(value), "value"); end
            if (parse_err)     begin n_perr++; pop_expect(EV_PERR, 1, "parse_err"); end
            if (frame_err)     begin n_ferr++; pop_expect(EV_FERR, 1, "frame_err"); end
            chk("value_hold", int'(value), exp_value);
        end
    end

    task automatic wait_bits(input int n);
        repeat (n * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        model_byte(b, !bad);
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bits(1);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ bad;
        wait_bits(1);
        rx = 1'b1;
`else
        rx = ~bad;
`endif
        wait_bits(1);
        rx = 1'b1;
        wait_bits(1);
    endtask

    task automatic send_line(input string s, input logic [7:0] term);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
        send_byte(term, 1'b0);
    endtask

    task automatic deltas(input string name, input int db, input int dv, input int dp, input int df);
        chk({name, "_bytes"}, n_byte - s_byte, db);
        chk({name, "_values"}, n_val - s_val, dv);
        chk({name, "_parse_errs"}, n_perr - s_perr, dp);
        chk({name, "_frame_errs"}, n_ferr - s_ferr, df);
        s_byte = n_byte; s_val = n_val; s_perr = n_perr; s_ferr = n_ferr;
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        wait_bits(2);
        chk("reset_value", int'(value), 0);

        send_line("123cm", CR);
        send_byte(LF, 1'b0);
        chk("lit_123", int'(value), 123);
        deltas("line_123cm", 7, 1, 0, 0);

        send_line("65535", CR);
        chk("lit_65535", int'(value), 65535);
        send_line("65536", CR);
        chk("lit_65536_holds", int'(value), 65535);
        deltas("overflow", 12, 1, 1, 0);

        send_line("000042", CR);
        send_line("00042", CR);
        chk("lit_leading_zeros", int'(value), 42);
        deltas("digit_limit", 13, 1, 1, 0);

        send_byte(8'h41, 1'b1);
        send_line("7", LF);
        chk("lit_bad_line_holds", int'(value), 42);
        send_line("7", LF);
        chk("lit_7", int'(value), 7);
        deltas("frame_error", 4, 1, 1, 1);

        rx = 1'b0;
        repeat (19) @(posedge clk);
        #1 rx = 1'b1;
        wait_bits(3);
        deltas("glitch", 0, 0, 0, 0);
        send_line("8", CR);
        chk("lit_after_glitch", int'(value), 8);
        deltas("after_glitch", 2, 1, 0, 0);

        send_byte(CR, 1'b0);
        send_byte(LF, 1'b0);
        send_line("c", CR);
        send_line("12c3", CR);
        send_line("5 m", CR);
        chk("lit_suffix_space", int'(value), 5);
        deltas("misc_lines", 13, 1, 2, 0);

        chk("queue_before_reset", exp_q.size(), 0);
        rx = 1'b0; wait_bits(1);
        rx = 1'b1; wait_bits(1);
        rx = 1'b0; wait_bits(1);
        rx = 1'b1; wait_bits(1);
        rx = 1'b0;
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1 rst = 1'b1;
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        line.delete();
        line_bad = 1'b0;
        chk("lit_value_after_reset", int'(value), 0);
        wait_bits(2);
        send_line("9", CR);
        chk("lit_9", int'(value), 9);
        deltas("reset_recovery", 2, 1, 0, 0);

`ifdef UART_RX_PARITY_EN
        send_line("42", CR);
        chk("lit_parity_42", int'(value), 42);
        send_byte(8'h34, 1'b1);
        send_line("2", CR);
        chk("lit_parity_bad_holds", int'(value), 42);
        deltas("parity", 5, 1, 1, 1);
`endif

        wait_bits(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
